// File: rtl/req_ack_if.sv
// req_ack_if: request/acknowledge bundle between a requester and the
// req_ack_responder.
//
// Parameters
//   ID_W      - request tag width
//   CNT_W     - completed-ack counter width
//   ACK_DELAY - responder latency; sizes the outstanding-request count
//
// Signals
//   en, req, req_id                    - requester -> responder
//   ack, ack_id, busy, outstanding,
//   ack_count, err_drop                - responder -> requester
//
// Modports
//   master - requester side
//   slave  - responder side
interface req_ack_if #(
    parameter int ID_W      = 4,
    parameter int CNT_W     = 8,
    parameter int ACK_DELAY = 3
);
    localparam int OUT_W = $clog2(ACK_DELAY + 1);

    logic             en;
    logic             req;
    logic [ID_W-1:0]  req_id;
    logic             ack;
    logic [ID_W-1:0]  ack_id;
    logic             busy;
    logic [OUT_W-1:0] outstanding;
    logic [CNT_W-1:0] ack_count;
    logic             err_drop;

    modport master (
        output en, req, req_id,
        input  ack, ack_id, busy, outstanding, ack_count, err_drop
    );

    modport slave (
        input  en, req, req_id,
        output ack, ack_id, busy, outstanding, ack_count, err_drop
    );
endinterface

// File: rtl/req_ack_responder.sv
// req_ack_responder: answers every accepted request with a one-cycle ack
// pulse exactly ACK_DELAY clock edges after the request was sampled,
// echoing the request tag. It tracks in-flight requests, counts completed
// acks (saturating) and flags refused requests in single-outstanding mode.
//
// Parameters
//   ACK_DELAY - edges from req sample to ack sample (1..16)
//   PIPELINED - 1: accept a request every edge; 0: one request in flight
//   ID_W      - tag width
//   CNT_W     - ack counter width
//
// Ports
//   clk  - clock, all state on the rising edge
//   rst  - asynchronous active-high reset
//   bus  - req_ack_if slave modport (en/req/req_id in; ack/ack_id/busy/
//          outstanding/ack_count/err_drop out)
module req_ack_responder #(
    parameter int ACK_DELAY = 3,
    parameter int PIPELINED = 1,
    parameter int ID_W      = 4,
    parameter int CNT_W     = 8
) (
    input  logic      clk,
    input  logic      rst,
    req_ack_if.slave  bus
);
    localparam int OUT_W = $clog2(ACK_DELAY + 1);

    logic            req_en;
    logic            accept;
    logic            drop_nxt;
    logic            ack_w;
    logic [ID_W-1:0] ack_id_w;

    assign req_en = bus.req && bus.en;

    if (PIPELINED != 0) begin : g_pipe
        // Delay line: entry 0 is loaded at the accepting edge, the last
        // entry is the registered ack itself, so the ack is sampled
        // ACK_DELAY edges after the request.
        logic [ACK_DELAY-1:0] vld_q, vld_d;
        logic [ID_W-1:0]      id_q [ACK_DELAY];
        logic [ID_W-1:0]      id_d [ACK_DELAY];

        always_comb begin
            accept   = req_en;
            drop_nxt = 1'b0;
            vld_d[0] = req_en;
            // Idle entries carry a zero tag so ack_id reads 0 without ack.
            id_d[0]  = req_en ? bus.req_id : '0;
            for (int i = 1; i < ACK_DELAY; i++) begin
                vld_d[i] = vld_q[i-1];
                id_d[i]  = id_q[i-1];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= '0;
                for (int i = 0; i < ACK_DELAY; i++) id_q[i] <= '0;
            end else begin
                vld_q <= vld_d;
                for (int i = 0; i < ACK_DELAY; i++) id_q[i] <= id_d[i];
            end
        end

        assign ack_w    = vld_q[ACK_DELAY-1];
        assign ack_id_w = id_q[ACK_DELAY-1];
    end else begin : g_fsm
        localparam int CW = $clog2(ACK_DELAY + 1);
        localparam logic [1:0] S_IDLE = 2'd0;
        localparam logic [1:0] S_WAIT = 2'd1;
        localparam logic [1:0] S_ACK  = 2'd2;

        logic [1:0]      state_q, state_d;
        logic [CW-1:0]   cnt_q, cnt_d;
        logic [ID_W-1:0] tag_q, tag_d;
        logic            ack_q, ack_d;
        logic [ID_W-1:0] ack_id_q, ack_id_d;

        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            tag_d    = tag_q;
            ack_d    = 1'b0;
            ack_id_d = '0;
            accept   = 1'b0;
            drop_nxt = 1'b0;

            case (state_q)
                S_WAIT: begin
                    if (cnt_q == CW'(1)) begin
                        state_d  = S_ACK;
                        ack_d    = 1'b1;
                        ack_id_d = tag_q;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // A new request is taken in IDLE or on the edge leaving ACK;
            // anything arriving while waiting is refused and reported.
            if (req_en) begin
                if (state_q != S_WAIT) begin
                    accept = 1'b1;
                    if (ACK_DELAY == 1) begin
                        state_d  = S_ACK;
                        ack_d    = 1'b1;
                        ack_id_d = bus.req_id;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CW'(ACK_DELAY - 1);
                        tag_d   = bus.req_id;
                    end
                end else begin
                    drop_nxt = 1'b1;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q  <= S_IDLE;
                cnt_q    <= '0;
                tag_q    <= '0;
                ack_q    <= 1'b0;
                ack_id_q <= '0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                tag_q    <= tag_d;
                ack_q    <= ack_d;
                ack_id_q <= ack_id_d;
            end
        end

        assign ack_w    = ack_q;
        assign ack_id_w = ack_id_q;
    end

    // Bookkeeping shared by both modes: the ack currently on the output is
    // the one sampled at the coming edge, so it retires there.
    logic [OUT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] ack_count_q, ack_count_d;
    logic             err_drop_q, err_drop_d;

    always_comb begin
        outstanding_d = outstanding_q;
        case ({accept, ack_w})
            2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
            2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase

        ack_count_d = ack_count_q;
        if (ack_w && (ack_count_q != '1)) ack_count_d = ack_count_q + CNT_W'(1);

        err_drop_d = drop_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_q <= '0;
            ack_count_q   <= '0;
            err_drop_q    <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            ack_count_q   <= ack_count_d;
            err_drop_q    <= err_drop_d;
        end
    end

    assign bus.ack         = ack_w;
    assign bus.ack_id      = ack_id_w;
    assign bus.busy        = (outstanding_q != '0);
    assign bus.outstanding = outstanding_q;
    assign bus.ack_count   = ack_count_q;
    assign bus.err_drop    = err_drop_q;
endmodule

// File: tb/tb_req_ack_responder.sv
// Bench for req_ack_responder: four instances with different
// ACK_DELAY / PIPELINED / CNT_W settings share one stimulus stream and are
// compared every cycle against a schedule-based reference model.
module tb_req_ack_responder;
    localparam int NI = 4;

    function automatic int md(input int n);   // ACK_DELAY per instance
        case (n) 0: return 3; 1: return 3; 2: return 1; default: return 2; endcase
    endfunction
    function automatic int mp(input int n);   // PIPELINED per instance
        case (n) 0: return 1; 1: return 0; 2: return 0; default: return 1; endcase
    endfunction
    function automatic int mc(input int n);   // CNT_W per instance
        case (n) 0: return 8; 1: return 8; default: return 2; endcase
    endfunction

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_r = 1'b0;
    logic       req_r = 1'b0;
    logic [3:0] id_r = 4'd0;

    always #5 clk = ~clk;

    req_ack_if #(.ID_W(4), .CNT_W(8), .ACK_DELAY(3)) if0 ();
    req_ack_if #(.ID_W(4), .CNT_W(8), .ACK_DELAY(3)) if1 ();
    req_ack_if #(.ID_W(4), .CNT_W(2), .ACK_DELAY(1)) if2 ();
    req_ack_if #(.ID_W(4), .CNT_W(2), .ACK_DELAY(2)) if3 ();

    assign if0.en = en_r; assign if0.req = req_r; assign if0.req_id = id_r;
    assign if1.en = en_r; assign if1.req = req_r; assign if1.req_id = id_r;
    assign if2.en = en_r; assign if2.req = req_r; assign if2.req_id = id_r;
    assign if3.en = en_r; assign if3.req = req_r; assign if3.req_id = id_r;

    req_ack_responder #(.ACK_DELAY(3), .PIPELINED(1), .ID_W(4), .CNT_W(8))
        u0 (.clk(clk), .rst(rst), .bus(if0));
    req_ack_responder #(.ACK_DELAY(3), .PIPELINED(0), .ID_W(4), .CNT_W(8))
        u1 (.clk(clk), .rst(rst), .bus(if1));
    req_ack_responder #(.ACK_DELAY(1), .PIPELINED(0), .ID_W(4), .CNT_W(2))
        u2 (.clk(clk), .rst(rst), .bus(if2));
    req_ack_responder #(.ACK_DELAY(2), .PIPELINED(1), .ID_W(4), .CNT_W(2))
        u3 (.clk(clk), .rst(rst), .bus(if3));

    // Reference model: a table of acks scheduled by absolute edge number.
    bit  sv  [NI][32];
    int  sid [NI][32];
    int  cnt_m  [NI];
    bit  drop_m [NI];
    int  edge_n = 0;

    int act_ack[NI], act_id[NI], act_busy[NI], act_out[NI], act_cnt[NI], act_drop[NI];
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < NI; n++) begin
            for (int s = 0; s < 32; s++) begin
                sv[n][s]  = 1'b0;
                sid[n][s] = 0;
            end
            cnt_m[n]  = 0;
            drop_m[n] = 1'b0;
        end
    endtask

    function automatic int pending(input int n);
        int c = 0;
        for (int s = 0; s < 32; s++) if (sv[n][s]) c++;
        return c;
    endfunction

    // Called just after each rising edge, using the inputs sampled there.
    task automatic model_edge();
        edge_n++;
        if (rst) return;
        for (int n = 0; n < NI; n++) begin
            int  now = edge_n % 32;
            bit  take;
            if (sv[n][now]) begin
                if (cnt_m[n] < (1 << mc(n)) - 1) cnt_m[n]++;
                sv[n][now]  = 1'b0;
                sid[n][now] = 0;
            end
            take = req_r && en_r && ((mp(n) != 0) || (pending(n) == 0));
            if (take) begin
                sv[n][(edge_n + md(n)) % 32]  = 1'b1;
                sid[n][(edge_n + md(n)) % 32] = int'(id_r);
            end
            drop_m[n] = (mp(n) == 0) && req_r && en_r && !take;
        end
    endtask

    task automatic sample();
        act_ack[0] = int'(if0.ack); act_id[0] = int'(if0.ack_id); act_busy[0] = int'(if0.busy);
        act_out[0] = int'(if0.outstanding); act_cnt[0] = int'(if0.ack_count); act_drop[0] = int'(if0.err_drop);
        act_ack[1] = int'(if1.ack); act_id[1] = int'(if1.ack_id); act_busy[1] = int'(if1.busy);
        act_out[1] = int'(if1.outstanding); act_cnt[1] = int'(if1.ack_count); act_drop[1] = int'(if1.err_drop);
        act_ack[2] = int'(if2.ack); act_id[2] = int'(if2.ack_id); act_busy[2] = int'(if2.busy);
        act_out[2] = int'(if2.outstanding); act_cnt[2] = int'(if2.ack_count); act_drop[2] = int'(if2.err_drop);
        act_ack[3] = int'(if3.ack); act_id[3] = int'(if3.ack_id); act_busy[3] = int'(if3.busy);
        act_out[3] = int'(if3.outstanding); act_cnt[3] = int'(if3.ack_count); act_drop[3] = int'(if3.err_drop);
    endtask

    task automatic check_all();
        sample();
        for (int n = 0; n < NI; n++) begin
            int nx = (edge_n + 1) % 32;
            int po = pending(n);
            chk($sformatf("u%0d.ack", n),         act_ack[n],  int'(sv[n][nx]));
            chk($sformatf("u%0d.ack_id", n),      act_id[n],   sv[n][nx] ? sid[n][nx] : 0);
            chk($sformatf("u%0d.outstanding", n), act_out[n],  po);
            chk($sformatf("u%0d.busy", n),        act_busy[n], (po != 0) ? 1 : 0);
            chk($sformatf("u%0d.ack_count", n),   act_cnt[n],  cnt_m[n]);
            chk($sformatf("u%0d.err_drop", n),    act_drop[n], int'(drop_m[n]));
        end
    endtask

    task automatic cyc(input bit e, input bit r, input int id);
        en_r  = e;
        req_r = r;
        id_r  = 4'(id);
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Asynchronous reset asserted mid-cycle, held across one edge.
    task automatic do_rst();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        en_r  = 1'b0;
        req_r = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        rst = 1'b0;
    endtask

    typedef struct {
        bit en; bit req; int id;
        int a0; int i0; int o0;   // u0: PIPELINED=1, ACK_DELAY=3
        int a1; int i1; int d1;   // u1: PIPELINED=0, ACK_DELAY=3
    } vec_t;

    vec_t tbl[17];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks_seen, drops_seen, cnt_before, ack_pat;

        // Expected values are those seen just after each edge.
        tbl[0]  = '{1'b1, 1'b1, 5, 0, 0, 1, 0, 0, 0};  // single request, id 5
        tbl[1]  = '{1'b1, 1'b0, 0, 0, 0, 1, 0, 0, 0};
        tbl[2]  = '{1'b1, 1'b0, 0, 1, 5, 1, 1, 5, 0};
        tbl[3]  = '{1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{1'b1, 1'b1, 1, 0, 0, 1, 0, 0, 0};  // burst ids 1..4
        tbl[6]  = '{1'b1, 1'b1, 2, 0, 0, 2, 0, 0, 1};
        tbl[7]  = '{1'b1, 1'b1, 3, 1, 1, 3, 1, 1, 1};
        tbl[8]  = '{1'b1, 1'b1, 4, 1, 2, 3, 0, 0, 0};
        tbl[9]  = '{1'b1, 1'b0, 0, 1, 3, 2, 0, 0, 0};
        tbl[10] = '{1'b1, 1'b0, 0, 1, 4, 1, 1, 4, 0};
        tbl[11] = '{1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0};
        tbl[12] = '{1'b1, 1'b1, 9, 0, 0, 1, 0, 0, 0};  // en low while in flight
        tbl[13] = '{1'b0, 1'b1, 7, 0, 0, 1, 0, 0, 0};
        tbl[14] = '{1'b0, 1'b1, 7, 1, 9, 1, 1, 9, 0};
        tbl[15] = '{1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0};
        tbl[16] = '{1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].en, tbl[i].req, tbl[i].id);
            chk($sformatf("tbl[%0d].u0.ack", i),    act_ack[0],  tbl[i].a0);
            chk($sformatf("tbl[%0d].u0.ack_id", i), act_id[0],   tbl[i].i0);
            chk($sformatf("tbl[%0d].u0.outst", i),  act_out[0],  tbl[i].o0);
            chk($sformatf("tbl[%0d].u1.ack", i),    act_ack[1],  tbl[i].a1);
            chk($sformatf("tbl[%0d].u1.ack_id", i), act_id[1],   tbl[i].i1);
            chk($sformatf("tbl[%0d].u1.drop", i),   act_drop[1], tbl[i].d1);
        end
        chk("tbl.u0.ack_count", act_cnt[0], 6);
        chk("tbl.u1.ack_count", act_cnt[1], 4);

        // Seven back-to-back requests into the single-outstanding instance.
        acks_seen  = 0;
        drops_seen = 0;
        cnt_before = act_cnt[1];
        for (int i = 0; i < 11; i++) begin
            cyc(1'b1, (i < 7), i + 1);
            acks_seen  += act_ack[1];
            drops_seen += act_drop[1];
        end
        chk("seq7.u1.acks", acks_seen, 3);
        chk("seq7.u1.drops", drops_seen, 4);
        chk("seq7.u1.ack_count_delta", act_cnt[1] - cnt_before, 3);

        // Reset one edge after an accept, then a fresh request.
        repeat (3) cyc(1'b1, 1'b0, 0);
        cyc(1'b1, 1'b1, 6);
        do_rst();
        chk("rst.u0.outstanding", act_out[0], 0);
        chk("rst.u0.ack", act_ack[0], 0);
        ack_pat = 0;
        cyc(1'b1, 1'b1, 10);
        ack_pat = act_ack[0];
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 0);
            ack_pat = (ack_pat << 1) | act_ack[0];
            if (i == 1) chk("rst.u0.next_ack_id", act_id[0], 10);
        end
        chk("rst.u0.ack_pattern", ack_pat, 4'b0010);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_rst();
            end else begin
                cyc(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 6),
                    int'($urandom_range(0, 15)));
            end
        end
        repeat (5) cyc(1'b1, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
